hs_sync_rx: RTL and testbench
=============================

HS_SYNC_RX -- requirements
Module: hs_sync_rx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  P_DATA_W  8  width of the transferred data word.
  P_SYNC_STAGES  2  flop stages in the request synchronizer chain; the SHALL minimum is 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  input  1  single clock, destination domain; all logic on posedge.
  rst  input  1  reset, synchronous, active-high.
  i_req  input  1  asynchronous toggle request from the source domain.
  i_data  input  P_DATA_W  source data bus; unsynchronized; held stable by the sender from the i_req toggle until o_ack is seen.
  o_ack  output  1  registered toggle acknowledge to the source domain.
  o_data  output  P_DATA_W  captured data word, registered.
  o_valid  output  1  o_data holds an unconsumed word.
  i_ready  input  1  downstream consumer accepts o_data.
  o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-003 i_req SHALL pass through a P_SYNC_STAGES-deep flop chain s[0..N-1], with s[0] <= i_req; no other logic reads i_req directly.
REQ-004 req_seen register SHALL hold the last consumed synchronized level; new_req = s[N-1] XOR req_seen.
REQ-005 FSM SHALL have exactly two states: IDLE and VALID.
REQ-006 In IDLE with new_req=1, on the next edge the block SHALL latch i_data into o_data, set o_valid=1, load req_seen <= s[N-1], and go to VALID.
REQ-007 Latency SHALL be fixed: the edge that first samples a new i_req level counts as edge 1, and o_valid is high after edge N+1. For N=2 that is after the 3rd edge.
REQ-008 In VALID, o_data and o_valid SHALL hold steady while i_ready=0.
REQ-009 In VALID with i_ready=1, the next edge SHALL clear o_valid, toggle o_ack, and return to IDLE.
REQ-010 new_req SHALL be ignored while in VALID. A pending toggle is captured no earlier than the first IDLE cycle after the handshake.
REQ-011 Back-to-back transfers: the minimum spacing SHALL be 1 IDLE cycle between o_valid deassert and the next capture.
REQ-012 A double toggle of i_req inside one synchronizer window returns i_req to its original level. It SHALL NOT produce a transfer; this is a sender protocol violation.
REQ-013 o_busy SHALL equal (state != IDLE) and is registered-derived, with no combinational path from the inputs.
REQ-014 No output SHALL depend combinationally on i_req, i_data or i_ready.

Reset
REQ-015 While rst=1 at a posedge, the block SHALL clear all registers: s[*]=0, req_seen=0, state=IDLE, o_data=0, o_valid=0, o_ack=0, and o_err=0 if present.
REQ-016 Reset mid-transfer SHALL discard any held word with no o_ack toggle; recovering the sender is a system-level responsibility.
REQ-017 If i_req=1 when rst is released, the block SHALL treat it as a new request, captured per REQ-007.

Configuration
REQ-018 Macro HS_SYNC_RX_ERR_EN controls protocol-error detection.
  Defined: adds output port o_err (1 bit). o_err is a sticky flag set on the edge where s[N-1] changes while state=VALID. It is cleared only by rst.
  Undefined: the o_err port and its logic are absent; behaviour is otherwise identical.

Verification
REQ-019 The bench SHALL cover the following scenarios.
  Single transfer (N=2, i_ready=1): toggle i_req 0->1 with i_data=8'hA5 -> o_valid high after edge 3, o_data=8'hA5, o_valid low and o_ack=1 one edge later.
  Backpressure: hold i_ready=0 for 10 cycles after o_valid -> o_data and o_valid stable for 10 cycles with o_ack unchanged; i_ready=1 -> o_ack toggles on the next edge.
  Back-to-back: sender toggles again immediately on seeing o_ack with 8'h3C -> second o_valid with 8'h3C; o_ack toggles twice in total, o_ack=0 at the end.
  Reset mid-VALID: assert rst for 1 cycle while o_valid=1 -> all outputs 0 the next cycle; no o_ack toggle; a subsequent i_req=1 is captured as new.
  Early toggle (HS_SYNC_RX_ERR_EN defined): toggle i_req while in VALID -> o_err=1 and stays 1 until rst. With the macro undefined -> no o_err port; the pending request is captured after the handshake.
  Parameter sweep: repeat the single-transfer scenario with P_SYNC_STAGES=3 and P_DATA_W=16 -> o_valid high after edge 4, full 16-bit word captured.

Source files
------------

// File: rtl/hs_sync_rx.sv
// -----------------------------------------------------------------------------
// hs_sync_rx
//   Receive side of a toggle-request / toggle-acknowledge clock-domain-crossing
//   handshake. A level change on i_req, after passing a P_SYNC_STAGES-deep
//   synchronizer, causes i_data (held stable by the sender) to be captured into
//   o_data. The word is held with o_valid until the consumer takes it with
//   i_ready, at which point o_ack toggles back to the sender.
//
// Parameters
//   P_DATA_W       width of the transferred data word
//   P_SYNC_STAGES  depth of the i_req synchronizer chain (must be >= 2)
//
// Ports
//   clk      destination-domain clock, all logic on posedge
//   rst      synchronous, active-high reset
//   i_req    asynchronous toggle request from the source domain
//   i_data   source data bus (stable while a request is outstanding)
//   i_ready  downstream consumer accepts o_data
//   o_ack    registered toggle acknowledge to the source domain
//   o_data   captured data word
//   o_valid  o_data holds an unconsumed word
//   o_busy   high whenever the FSM is not idle
//   o_err    (only with HS_SYNC_RX_ERR_EN) sticky flag: synchronized request
//            level changed while a word was still held; cleared only by rst
//
// Configuration macro
//   HS_SYNC_RX_ERR_EN  when defined, adds the o_err port and its detection logic
// -----------------------------------------------------------------------------
module hs_sync_rx #(
    parameter int P_DATA_W      = 8,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [P_DATA_W-1:0] i_data,
    input  logic                i_ready,
    output logic                o_ack,
    output logic [P_DATA_W-1:0] o_data,
    output logic                o_valid,
    output logic                o_busy
`ifdef HS_SYNC_RX_ERR_EN
    ,
    output logic                o_err
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] VALID = 1'b1;

    logic [P_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                     req_seen_q, req_seen_d;
    logic [0:0]               state_q, state_d;
    logic [P_DATA_W-1:0]      data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ack_q, ack_d;
    logic                     req_lvl;
    logic                     new_req;

    always_comb begin
        // i_req enters only at sync[0]; everything downstream uses the last stage
        sync_d     = {sync_q[P_SYNC_STAGES-2:0], i_req};
        req_lvl    = sync_q[P_SYNC_STAGES-1];
        new_req    = req_lvl ^ req_seen_q;

        state_d    = state_q;
        req_seen_d = req_seen_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ack_d      = ack_q;

        case (state_q)
            IDLE: begin
                if (new_req) begin
                    data_d     = i_data;
                    valid_d    = 1'b1;
                    req_seen_d = req_lvl;
                    state_d    = VALID;
                end
            end
            VALID: begin
                // A request arriving here stays pending (req_seen untouched)
                // and is picked up from IDLE after this handshake completes.
                if (i_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            req_seen_q <= req_seen_d;
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
        end
    end

`ifdef HS_SYNC_RX_ERR_EN
    logic err_q, err_d;

    always_comb begin
        // Flag the edge on which the synchronized level moves while a word is
        // still held: the sender toggled again before seeing o_ack.
        err_d = err_q |
                ((state_q == VALID) && (sync_d[P_SYNC_STAGES-1] != sync_q[P_SYNC_STAGES-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

    assign o_ack   = ack_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_hs_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_hs_sync_rx
//   Self-checking bench for hs_sync_rx. Two instances share clk/rst:
//     dut_a : P_SYNC_STAGES=2, P_DATA_W=8
//     dut_b : P_SYNC_STAGES=3, P_DATA_W=16
//   Every cycle both instances are compared with a transaction-level model that
//   treats the synchronizer as a pure N-edge delay of i_req.
// -----------------------------------------------------------------------------
module tb_hs_sync_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req = 1'b0, a_ready = 1'b0;
    logic [7:0]  a_data = '0;
    logic        a_ack, a_valid, a_busy;
    logic [7:0]  a_odata;

    logic        b_req = 1'b0, b_ready = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ack, b_valid, b_busy;
    logic [15:0] b_odata;

`ifdef HS_SYNC_RX_ERR_EN
    logic        a_err, b_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hs_sync_rx #(.P_DATA_W(8), .P_SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .i_req(a_req), .i_data(a_data), .i_ready(a_ready),
        .o_ack(a_ack), .o_data(a_odata), .o_valid(a_valid), .o_busy(a_busy)
`ifdef HS_SYNC_RX_ERR_EN
        , .o_err(a_err)
`endif
    );

    hs_sync_rx #(.P_DATA_W(16), .P_SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .i_req(b_req), .i_data(b_data), .i_ready(b_ready),
        .o_ack(b_ack), .o_data(b_odata), .o_valid(b_valid), .o_busy(b_busy)
`ifdef HS_SYNC_RX_ERR_EN
        , .o_err(b_err)
`endif
    );

    // ---------------- reference model ----------------
    // hist holds past i_req samples (bit 0 = newest); the synchronized level
    // seen before an edge is the sample taken n edges earlier.
    logic [7:0]  m_hist  [2];
    logic        m_valid [2];
    logic        m_ack   [2];
    logic        m_err   [2];
    logic        m_seen  [2];
    logic [15:0] m_data  [2];

    task automatic model_edge(input int k, input int n, input logic r,
                              input logic req, input logic [15:0] d, input logic rdy);
        logic [7:0] nh;
        logic lvl, nlvl;
        if (r) begin
            m_hist[k] = '0; m_valid[k] = 0; m_ack[k] = 0;
            m_err[k] = 0;   m_seen[k] = 0;  m_data[k] = '0;
        end else begin
            lvl  = m_hist[k][n-1];
            nh   = {m_hist[k][6:0], req};
            nlvl = nh[n-1];
            if (m_valid[k] && (nlvl != lvl)) m_err[k] = 1'b1;
            if (!m_valid[k] && (lvl != m_seen[k])) begin
                m_data[k]  = d;
                m_valid[k] = 1'b1;
                m_seen[k]  = lvl;
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 1'b0;
                m_ack[k]   = ~m_ack[k];
            end
            m_hist[k] = nh;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // one clock: model advances on the edge, outputs compared on the negedge
    task automatic step();
        @(posedge clk);
        model_edge(0, 2, rst, a_req, {8'h00, a_data}, a_ready);
        model_edge(1, 3, rst, b_req, b_data, b_ready);
        @(negedge clk);
        check("a_valid", {31'd0, a_valid}, {31'd0, m_valid[0]});
        check("a_data",  {24'd0, a_odata}, {16'd0, m_data[0]});
        check("a_ack",   {31'd0, a_ack},   {31'd0, m_ack[0]});
        check("a_busy",  {31'd0, a_busy},  {31'd0, m_valid[0]});
        check("b_valid", {31'd0, b_valid}, {31'd0, m_valid[1]});
        check("b_data",  {16'd0, b_odata}, {16'd0, m_data[1]});
        check("b_ack",   {31'd0, b_ack},   {31'd0, m_ack[1]});
        check("b_busy",  {31'd0, b_busy},  {31'd0, m_valid[1]});
`ifdef HS_SYNC_RX_ERR_EN
        check("a_err",   {31'd0, a_err},   {31'd0, m_err[0]});
        check("b_err",   {31'd0, b_err},   {31'd0, m_err[1]});
`endif
    endtask

    task automatic wait_a_valid(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (a_valid === 1'b1) got = 1'b1;
        end
        check(name, {31'd0, got}, 32'd1);
    endtask

    typedef struct {
        logic       rst;
        logic       req;
        logic [7:0] data;
        logic       ready;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_ack;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // single transfer, N=2: valid after edge 3, ack one edge later
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; a_req = tbl[i].req; a_data = tbl[i].data; a_ready = tbl[i].ready;
            step();
            check($sformatf("tbl%0d_valid", i), {31'd0, a_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d_data", i),  {24'd0, a_odata}, {24'd0, tbl[i].e_data});
            check($sformatf("tbl%0d_ack", i),   {31'd0, a_ack},   {31'd0, tbl[i].e_ack});
        end

        // backpressure: hold word for 10 cycles, ack only after ready
        rst = 1'b1; a_req = 1'b0; a_ready = 1'b0; step();
        rst = 1'b0; a_req = 1'b1; a_data = 8'h5A;
        wait_a_valid("bp_wait");
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", {31'd0, a_valid}, 32'd1);
            check("bp_data",  {24'd0, a_odata}, 32'h5A);
            check("bp_ack",   {31'd0, a_ack},   32'd0);
        end
        a_ready = 1'b1; step();
        check("bp_ack_tog", {31'd0, a_ack},   32'd1);
        check("bp_vld_clr", {31'd0, a_valid}, 32'd0);

        // back-to-back: sender toggles again as soon as it sees ack
        a_req = 1'b0; a_data = 8'h3C;
        wait_a_valid("b2b_wait");
        check("b2b_data", {24'd0, a_odata}, 32'h3C);
        step();
        check("b2b_ack_end", {31'd0, a_ack}, 32'd0);

        // reset while holding a word: everything clears, no ack toggle
        a_ready = 1'b0; a_req = 1'b1; a_data = 8'h77;
        wait_a_valid("rst_wait");
        rst = 1'b1; step();
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_data",  {24'd0, a_odata}, 32'd0);
        check("rst_ack",   {31'd0, a_ack},   32'd0);
        check("rst_busy",  {31'd0, a_busy},  32'd0);
        rst = 1'b0;                 // i_req still 1: seen as a new request
        wait_a_valid("rst_recap");
        check("rst_recap_data", {24'd0, a_odata}, 32'h77);
        a_ready = 1'b1; step();
        check("rst_recap_ack", {31'd0, a_ack}, 32'd1);

        // early toggle while holding a word
        rst = 1'b1; a_req = 1'b0; a_ready = 1'b0; step();
        rst = 1'b0; a_req = 1'b1; a_data = 8'h11;
        wait_a_valid("early_wait");
        a_req = 1'b0; a_data = 8'h22;
        for (int i = 0; i < 4; i++) step();
        check("early_hold", {24'd0, a_odata}, 32'h11);
`ifdef HS_SYNC_RX_ERR_EN
        check("early_err", {31'd0, a_err}, 32'd1);
`endif
        a_ready = 1'b1; step();
        check("early_ack", {31'd0, a_ack}, 32'd1);
        a_ready = 1'b0;
        wait_a_valid("early_pending");
        check("early_pend_data", {24'd0, a_odata}, 32'h22);
        a_ready = 1'b1; step();
`ifdef HS_SYNC_RX_ERR_EN
        check("err_sticky", {31'd0, a_err}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("err_rst", {31'd0, a_err}, 32'd0);
`endif

        // parameter sweep: N=3, 16-bit word, valid after edge 4
        rst = 1'b1; b_req = 1'b0; b_ready = 1'b1; a_req = 1'b0; step();
        rst = 1'b0; b_req = 1'b1; b_data = 16'hBEEF;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("sweep_e%0d_valid", e), {31'd0, b_valid}, (e == 4) ? 32'd1 : 32'd0);
        end
        check("sweep_data", {16'd0, b_odata}, 32'hBEEF);
        step();
        check("sweep_ack", {31'd0, b_ack}, 32'd1);

        // randomized traffic on both instances against the model
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 5) == 0) a_req = ~a_req;
            if ($urandom_range(0, 6) == 0) b_req = ~b_req;
            a_data  = 8'($urandom);
            b_data  = 16'($urandom);
            a_ready = ($urandom_range(0, 2) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
